// File: rtl/ro_phase_meter.sv
// Ring-oscillator phase meter: counts rising edges of one synchronised tap over a
// programmable gate and snapshots all taps. Serial readout enabled by RO_METER_SERIAL_EN.
module ro_phase_meter #(
   parameter int CNT_W  = 16,
   parameter int SNAP_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [SNAP_W-1:0] phases_in,
   input  logic [3:0]        sel,
   input  logic [3:0]        gate_sel,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  count,
   output logic              overflow,
   output logic [SNAP_W-1:0] snapshot,
   input  logic              sclk,
   output logic              sdo
);

   localparam int TMR_W = 15;

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_GATE, S_LATCH} state_t;

   state_t             state_q, state_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic [3:0]         sel_q, sel_d;
   logic [3:0]         gate_q, gate_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovfi_q, ovfi_d;
   logic [SNAP_W-1:0]  ph_s1_q, ph_s2_q;
   logic               prev_q, edge_q;
   logic               done_q;
   logic [CNT_W-1:0]   count_q;
   logic               ovf_q;
   logic [SNAP_W-1:0]  snap_q;
   logic               capture;

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      sel_d   = sel_q;
      gate_d  = gate_q;
      cnt_d   = cnt_q;
      ovfi_d  = ovfi_q;
      capture = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               sel_d   = sel;
               gate_d  = (gate_sel > 4'd9) ? 4'd9 : gate_sel;
               cnt_d   = '0;
               ovfi_d  = 1'b0;
               tmr_d   = TMR_W'(2);
               state_d = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (tmr_q == '0) begin
               tmr_d   = TMR_W'((32'd64 << gate_q) - 32'd1);
               state_d = S_GATE;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         S_GATE: begin
            if (edge_q) begin
               if (cnt_q == {CNT_W{1'b1}}) ovfi_d = 1'b1;
               else                        cnt_d  = cnt_q + CNT_W'(1);
            end
            if (tmr_q == '0) state_d = S_LATCH;
            else             tmr_d   = tmr_q - TMR_W'(1);
         end
         S_LATCH: begin
            capture = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         tmr_q   <= '0;
         sel_q   <= '0;
         gate_q  <= '0;
         cnt_q   <= '0;
         ovfi_q  <= 1'b0;
         ph_s1_q <= '0;
         ph_s2_q <= '0;
         prev_q  <= 1'b0;
         edge_q  <= 1'b0;
         done_q  <= 1'b0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         snap_q  <= '0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         sel_q   <= sel_d;
         gate_q  <= gate_d;
         cnt_q   <= cnt_d;
         ovfi_q  <= ovfi_d;
         ph_s1_q <= phases_in;
         ph_s2_q <= ph_s1_q;
         // prev/edge keep running through SETTLE so GATE starts with a clean history
         prev_q  <= ph_s2_q[sel_q];
         edge_q  <= ph_s2_q[sel_q] & ~prev_q;
         done_q  <= capture;
         if (capture) begin
            count_q <= cnt_q;
            ovf_q   <= ovfi_q;
            snap_q  <= ph_s2_q;
         end
      end
   end

   assign busy     = (state_q != S_IDLE);
   assign done     = done_q;
   assign count    = count_q;
   assign overflow = ovf_q;
   assign snapshot = snap_q;

`ifdef RO_METER_SERIAL_EN
   localparam int SR_W = 1 + CNT_W + SNAP_W;

   logic [2:0]      sck_q;
   logic [SR_W-1:0] sr_q;
   logic            sck_rise;

   // sck_q = {prev, sync2, sync1}
   assign sck_rise = sck_q[1] & ~sck_q[2];

   always_ff @(posedge clk) begin
      if (rst) begin
         sck_q <= '0;
         sr_q  <= '0;
      end else begin
         sck_q <= {sck_q[1:0], sclk};
         if (capture)       sr_q <= {ovfi_q, cnt_q, ph_s2_q};
         else if (sck_rise) sr_q <= {sr_q[SR_W-2:0], 1'b0};
      end
   end

   assign sdo = sr_q[SR_W-1];
`else
   logic sclk_unused;
   assign sclk_unused = sclk;
   assign sdo         = 1'b0;
`endif

endmodule

// File: tb/tb_ro_phase_meter.sv
// Scoreboard bench for ro_phase_meter: 16-bit and 8-bit counter instances share stimulus,
// expected results come from counting sampled tap rising edges over the gate window.
module tb_ro_phase_meter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] phases_in = '0;
   logic [3:0]  sel = '0, gate_sel = '0;
   logic        start = 1'b0, sclk = 1'b0;
   logic        busy, done, overflow, sdo;
   logic [15:0] count, snapshot;
   logic        busy8, done8, overflow8, sdo8;
   logic [7:0]  count8;
   logic [15:0] snapshot8;

   ro_phase_meter dut (
      .clk(clk), .rst(rst), .phases_in(phases_in), .sel(sel), .gate_sel(gate_sel),
      .start(start), .busy(busy), .done(done), .count(count), .overflow(overflow),
      .snapshot(snapshot), .sclk(sclk), .sdo(sdo));

   ro_phase_meter #(.CNT_W(8)) dut8 (
      .clk(clk), .rst(rst), .phases_in(phases_in), .sel(sel), .gate_sel(gate_sel),
      .start(start), .busy(busy8), .done(done8), .count(count8), .overflow(overflow8),
      .snapshot(snapshot8), .sclk(sclk), .sdo(sdo8));

   always #5 clk = ~clk;

   typedef struct {
      int          done_cyc;
      int          busy_len;
      logic [15:0] cnt16;
      logic        ovf16;
      logic [7:0]  cnt8;
      logic        ovf8;
      logic [15:0] snap;
   } exp_t;

   exp_t q[$];
   exp_t last_exp;
   int   tests = 0, fails = 0;
   int   cyc = 0;
   int   busy_cnt = 0;

   // Tap waveform: base vector, with bit gb_tap toggling every gb_h samples (0 = static)
   logic [15:0] gb_base = '0;
   int          gb_tap = 0, gb_h = 0, gb_off = 0;

   function automatic logic [15:0] phase_fn(int p);
      logic [15:0] v;
      v = gb_base;
      if (gb_h > 0) v[gb_tap] = (((p + gb_off) / gb_h) % 2) != 0;
      return v;
   endfunction

   // start accepted at posedge a: rising edges of samples a+1..a+N are counted
   function automatic exp_t model(int a, int gs);
      exp_t e;
      int   n, rises;
      logic [15:0] cur, prv;
      n = 64 << ((gs > 9) ? 9 : gs);
      rises = 0;
      for (int p = a + 1; p <= a + n; p++) begin
         cur = phase_fn(p);
         prv = phase_fn(p - 1);
         if (cur[gb_tap] && !prv[gb_tap]) rises++;
      end
      e.done_cyc = a + n + 4;
      e.busy_len = n + 4;
      e.cnt16    = (rises > 65535) ? 16'hFFFF : 16'(rises);
      e.ovf16    = rises > 65535;
      e.cnt8     = (rises > 255) ? 8'hFF : 8'(rises);
      e.ovf8     = rises > 255;
      e.snap     = phase_fn(a + n + 2);
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) phases_in = phase_fn(cyc + 1);

   // Monitor: pops one expectation per done pulse
   always @(negedge clk) begin
      exp_t e;
      if (busy === 1'b1) busy_cnt++;
      else if (done === 1'b1) begin
         if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done at cycle %0d: got done=1 expected none", cyc);
         end else begin
            e = q.pop_front();
            chk("done_cycle", cyc, e.done_cyc);
            chk("busy_len", busy_cnt, e.busy_len);
            chk("count16", count, e.cnt16);
            chk("ovf16", overflow, e.ovf16);
            chk("done8", done8, 1);
            chk("count8", count8, e.cnt8);
            chk("ovf8", overflow8, e.ovf8);
            chk("snap16", snapshot, e.snap);
            chk("snap8", snapshot8, e.snap);
         end
         busy_cnt = 0;
      end else busy_cnt = 0;
   end

   task automatic run(input int s, input int gs, input int h, input int off,
                      input logic [15:0] base, input bit push, input bit twice);
      int a, n;
      @(posedge clk);
      #1;
      gb_base = base;
      gb_tap  = s;
      gb_h    = h;
      gb_off  = off;
      @(negedge clk);
      sel      = 4'(s);
      gate_sel = 4'(gs);
      start    = 1'b1;
      a = cyc + 1;
      n = 64 << ((gs > 9) ? 9 : gs);
      if (push) begin
         last_exp = model(a, gs);
         q.push_back(last_exp);
         if (twice) begin
            last_exp = model(a + n + 5, gs);
            q.push_back(last_exp);
         end
      end
      if (twice) while (cyc < a + n + 5) @(negedge clk);
      else       @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int lim;
      lim = cyc + 40000;
      while (q.size() != 0 && cyc < lim) @(negedge clk);
      if (q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL done_timeout: %0d results outstanding, expected 0", q.size());
         q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic serial_read(input logic [32:0] w);
      logic [32:0] e;
`ifdef RO_METER_SERIAL_EN
      e = w;
`else
      e = '0;
`endif
      repeat (4) @(negedge clk);
      chk("sdo_first", sdo, e[32]);
      for (int k = 1; k <= 33; k++) begin
         sclk = 1'b1;
         repeat (4) @(negedge clk);
         chk("sdo_bit", sdo, (k <= 32) ? e[32-k] : 1'b0);
         sclk = 1'b0;
         repeat (4) @(negedge clk);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_count", count, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_snap", snapshot, 0);
      chk("rst_sdo", sdo, 0);

      // tap 3 toggling every 4 cycles, shortest gate
      run(3, 0, 4, 1, 16'h0000, 1, 0);
      wait_idle();

      for (int i = 0; i < 8; i++) begin
         run($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 7),
             $urandom_range(0, 15), 16'($urandom), 1, (i % 3) == 2);
         wait_idle();
      end

      // reset mid-gate: no done may follow
      run(3, 2, 2, 0, 16'h1234, 0, 0);
      repeat (120) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_busy", busy, 0);
      chk("midrst_count", count, 0);
      chk("midrst_snap", snapshot, 0);
      chk("midrst_ovf", overflow, 0);
      chk("midrst_sdo", sdo, 0);
      repeat (400) @(negedge clk);

      // longest gate at clk/4 tap rate: the 8-bit counter saturates
      run(5, 9, 2, 0, 16'h5A5A, 1, 0);
      wait_idle();
      serial_read({last_exp.ovf16, last_exp.cnt16, last_exp.snap});

      // gate_sel clamps to 9; start and sel/gate_sel changes while busy are ignored
      run(9, 15, 3, 2, 16'h0F0F, 1, 0);
      repeat (100) @(negedge clk);
      start    = 1'b1;
      sel      = 4'd2;
      gate_sel = 4'd0;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      repeat (20) @(negedge clk);

      // static vector, nothing to count
      run(0, 0, 0, 0, 16'hA5C3, 1, 0);
      wait_idle();
      serial_read({1'b0, 16'h0000, 16'hA5C3});

      chk("queue_empty", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ro_phase_meter.md
# ro_phase_meter

Measurement stage placed directly downstream of the instrumented ring oscillator. It takes the oscillator's 16 asynchronous phase taps, synchronises one selected tap into the system clock domain, and counts its rising edges over a programmable gate window. At the end of the window it captures a snapshot of all 16 phases. Count, overflow and snapshot are presented in parallel and, optionally, through a slow serial readout so the tile's few pins can report results.

## Interface
Parameters:
- `CNT_W`, 16: edge-counter width in bits.
- `SNAP_W`, 16: phase-vector width; must equal the oscillator's phase count.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `phases_in`  in  SNAP_W  asynchronous oscillator taps.
- `sel`  in  4  tap to count. Sampled only on an accepted `start`.
- `gate_sel`  in  4  gate length is 64 << min(gate_sel, 9) clk cycles. Sampled on an accepted `start`.
- `start`  in  1  level; accepted on any cycle where it is high in IDLE.
- `busy`  out  1  high from SETTLE through LATCH.
- `done`  out  1  one-cycle pulse after LATCH.
- `count`  out  CNT_W  edges counted in the last gate; saturating.
- `overflow`  out  1  set if the counter saturated during the last gate.
- `snapshot`  out  SNAP_W  synchronised phase vector at gate end.
- `sclk`  in  1  asynchronous serial-read clock.
- `sdo`  out  1  serial data out.

## Operation
- Every `phases_in` bit passes through a 2-FF synchroniser. Edge detect: a rising edge is `sync[sel_q] & ~prev`.
- States:
  - IDLE: `busy`=0. On `start`, latch `sel_q` and `gate_q`, clear the edge counter and internal overflow, then go to SETTLE.
  - SETTLE: lasts 3 cycles and flushes the synchroniser and `prev`. No counting.
  - GATE: lasts N = 64 << min(gate_q, 9) cycles. Increments the counter on each detected edge.
    - The counter saturates at 2^CNT_W − 1. An edge arriving at saturation sets internal overflow.
  - LATCH: lasts 1 cycle. Copies counter→`count`, overflow→`overflow`, synchronised vector→`snapshot`, then goes to IDLE.
- `done` is high in the first IDLE cycle after LATCH.
- `start` is ignored while `busy`. `start` held high re-arms in the cycle after `done`.
- Changes to `sel`/`gate_sel` while busy have no effect.
- Reset (any state): FSM→IDLE. Outputs reset as follows:
  - `busy`, `done`, `overflow`, `sdo` = 0.
  - `count`, `snapshot` = 0.
  - Synchronisers = 0.
  - Shift register = 0.
- Maximum measurable tap rate is clk/2. Faster inputs alias, which is the reason for the oscillator's prescaler/hold.

## Timing
- `start` high in IDLE on cycle 0 gives:
  - `busy`=1 on cycles 1 through 4+N.
  - SETTLE on cycles 1–3.
  - GATE on cycles 4 through 3+N.
  - LATCH on cycle 4+N.
  - `count`/`overflow`/`snapshot` valid and `done`=1 on cycle 5+N.
- Phase-edge-to-count latency is 3 cycles (2 sync + edge register).
- Parallel outputs hold their values until the next LATCH or reset.

## Configuration
- `RO_METER_SERIAL_EN` defined:
  - `sclk` passes through a 2-FF synchroniser and rising-edge detector.
  - A (1+CNT_W+SNAP_W)-bit shift register loads {`overflow`, `count`, `snapshot`} on the LATCH edge.
  - `sdo` is the register MSB, so `overflow` is presented first, before any `sclk` edge.
  - Each synchronised `sclk` rising edge shifts left with zero fill.
  - If a load and a shift happen on the same cycle, the load wins.
  - After all bits have been shifted, `sdo`=0.
- `RO_METER_SERIAL_EN` undefined: no shift register; `sdo` tied 0; `sclk` unused.

## Test plan
- Reset mid-GATE, with `sel`=3 toggling: `busy`=0 the next cycle, `count`=0, `snapshot`=0. No `done` follows.
- `phases_in[3]` toggling every 4 clk cycles from before `start`, `sel`=3, `gate_sel`=0: `done` at cycle 69, `count`=8, `overflow`=0.
- `CNT_W`=8, tap toggling every 2 cycles, `gate_sel`=9 (N=32768): `count`=255, `overflow`=1.
- `gate_sel`=15 behaves as 9: `busy` lasts 32772 cycles. A second `start` pulse while busy is ignored and gives exactly one `done`.
- `phases_in`=16'hA5C3 held static, `sel`=0: `count`=0, `snapshot`=16'hA5C3.
- `RO_METER_SERIAL_EN` defined, after the previous test: `sdo`=0 before any `sclk` edge, then the next 32 `sclk` edges read 16'h0000 then 16'hA5C3, then `sdo`=0.
